maxpool_stream_ctrl: RTL and testbench

- Streaming max-pool scheduler for one raster-scanned image frame.
- Accepts pixels over a valid/ready interface and keeps KERNEL_DIM-1 line buffers plus a KERNEL_DIM x KERNEL_DIM window shift register.
- Decides which pixel positions complete a stride-aligned window. Emits the unsigned maximum of each such window on a registered, back-pressurable output.
- Sits between the pixel source (camera/DMA) and downstream feature consumers.

---
 rtl/maxpool_stream_ctrl.sv | 139 +++++++++++++
 tb/tb_maxpool_stream_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream_ctrl.sv
// Streaming KxK max-pool with stride S over one raster-scanned frame.
// K-1 line buffers feed a window shift register; results sit in one back-pressurable output register.
module maxpool_stream_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int KERNEL_DIM = 3,
    parameter int STRIDE     = 2,
    parameter int ROW_SIZE   = 540,
    parameter int COL_SIZE   = 960
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pixel,
    input  logic                  in_sof,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pixel,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic                  frame_done,
    output logic                  busy
);
    localparam int K1     = KERNEL_DIM - 1;
    localparam int CW     = $clog2(ROW_SIZE);
    localparam int RW     = $clog2(COL_SIZE);
    localparam int PW     = $clog2(STRIDE + 1);
    localparam int OW     = (ROW_SIZE - KERNEL_DIM) / STRIDE + 1;
    localparam int OH     = (COL_SIZE - KERNEL_DIM) / STRIDE + 1;
    localparam int LAST_C = K1 + (OW - 1) * STRIDE;
    localparam int LAST_R = K1 + (OH - 1) * STRIDE;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                state;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [PW-1:0]         col_phase;
    logic [PW-1:0]         row_phase;
    logic [DATA_WIDTH-1:0] lb      [K1][ROW_SIZE];
    logic [DATA_WIDTH-1:0] win     [KERNEL_DIM][KERNEL_DIM];
    logic [DATA_WIDTH-1:0] new_col [KERNEL_DIM];
    logic [DATA_WIDTH-1:0] win_max;
    logic                  accept, take, emit;
    logic [CW-1:0]         cur_col;
    logic [RW-1:0]         cur_row;
    logic [PW-1:0]         cur_col_phase;
    logic [PW-1:0]         cur_row_phase;

    // Phase is meaningful once the index reaches K-1; it counts down to the next aligned window.
    function automatic logic [PW-1:0] step_phase(input logic early, input logic [PW-1:0] ph);
        if (early) return '0;
        if (ph == '0) return PW'(STRIDE - 1);
        return ph - 1'b1;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign busy     = (state != IDLE) || out_valid;
    assign accept   = in_valid && in_ready;
    assign take     = accept && (in_sof || state == STREAM);

    // A start-of-frame pixel always lands at (0,0), even mid-frame.
    assign cur_col       = in_sof ? '0 : col;
    assign cur_row       = in_sof ? '0 : row;
    assign cur_col_phase = in_sof ? '0 : col_phase;
    assign cur_row_phase = in_sof ? '0 : row_phase;

    assign emit = take && cur_row >= RW'(K1) && cur_col >= CW'(K1) &&
                  cur_row_phase == '0 && cur_col_phase == '0;

    always_comb begin
        for (int i = 0; i < K1; i++) new_col[i] = lb[K1-1-i][cur_col];
        new_col[K1] = in_pixel;
    end

    // Max over the window as it will look after this pixel shifts in.
    always_comb begin
        win_max = new_col[0];
        for (int i = 1; i < KERNEL_DIM; i++)
            if (new_col[i] > win_max) win_max = new_col[i];
        for (int j = 0; j < K1; j++)
            for (int i = 0; i < KERNEL_DIM; i++)
                if (win[j][i] > win_max) win_max = win[j][i];
    end

    always_ff @(posedge clk) begin
        if (take) begin
            lb[0][cur_col] <= in_pixel;
            for (int i = 1; i < K1; i++) lb[i][cur_col] <= lb[i-1][cur_col];
            for (int i = 0; i < KERNEL_DIM; i++) win[0][i] <= new_col[i];
            for (int j = 1; j < KERNEL_DIM; j++)
                for (int i = 0; i < KERNEL_DIM; i++) win[j][i] <= win[j-1][i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            col_phase  <= '0;
            row_phase  <= '0;
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            out_eol    <= 1'b0;
            out_eof    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_valid && out_ready && out_eof;
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (emit) begin
                out_valid <= 1'b1;
                out_pixel <= win_max;
                out_eol   <= cur_col == CW'(LAST_C);
                out_eof   <= cur_col == CW'(LAST_C) && cur_row == RW'(LAST_R);
            end
            if (take) begin
                state <= STREAM;
                if (cur_col == CW'(ROW_SIZE - 1)) begin
                    col       <= '0;
                    col_phase <= '0;
                    if (cur_row == RW'(COL_SIZE - 1)) begin
                        state     <= IDLE;
                        row       <= '0;
                        row_phase <= '0;
                    end else begin
                        row       <= cur_row + 1'b1;
                        row_phase <= step_phase(cur_row < RW'(K1), cur_row_phase);
                    end
                end else begin
                    col       <= cur_col + 1'b1;
                    col_phase <= step_phase(cur_col < CW'(K1), cur_col_phase);
                    row       <= cur_row;
                    row_phase <= cur_row_phase;
                end
            end
        end
    end
endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// Scoreboard bench for maxpool_stream_ctrl: three instances with different K/S/W/H,
// a frame-level reference model feeding an expectation queue, and a decoupled output monitor.
module tb_maxpool_stream_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid  [3];
    logic       in_sof    [3];
    logic       out_ready [3];
    logic [7:0] in_pixel  [3];
    logic       in_ready  [3];
    logic       out_valid [3];
    logic       out_eol   [3];
    logic       out_eof   [3];
    logic       frame_done[3];
    logic       busy      [3];
    logic [7:0] out_pixel [3];

    int KP[3] = '{2, 3, 3};
    int SP[3] = '{2, 1, 3};
    int WP[3] = '{4, 4, 7};
    int HP[3] = '{4, 4, 7};

    maxpool_stream_ctrl #(.DATA_WIDTH(8), .KERNEL_DIM(2), .STRIDE(2), .ROW_SIZE(4), .COL_SIZE(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_pixel(in_pixel[0]),
        .in_sof(in_sof[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_pixel(out_pixel[0]),
        .out_eol(out_eol[0]), .out_eof(out_eof[0]), .frame_done(frame_done[0]), .busy(busy[0]));
    maxpool_stream_ctrl #(.DATA_WIDTH(8), .KERNEL_DIM(3), .STRIDE(1), .ROW_SIZE(4), .COL_SIZE(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_pixel(in_pixel[1]),
        .in_sof(in_sof[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_pixel(out_pixel[1]),
        .out_eol(out_eol[1]), .out_eof(out_eof[1]), .frame_done(frame_done[1]), .busy(busy[1]));
    maxpool_stream_ctrl #(.DATA_WIDTH(8), .KERNEL_DIM(3), .STRIDE(3), .ROW_SIZE(7), .COL_SIZE(7)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_pixel(in_pixel[2]),
        .in_sof(in_sof[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_pixel(out_pixel[2]),
        .out_eol(out_eol[2]), .out_eof(out_eof[2]), .frame_done(frame_done[2]), .busy(busy[2]));

    typedef struct {
        int         inst;
        logic [7:0] pix;
        logic       eol;
        logic       eof;
        int         cyc;
        bit         chk_lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   lat_en = 1'b1;
    bit   rand_rdy = 1'b0;
    bit   fd_pend[3] = '{0, 0, 0};
    int   mr[3], mc[3];
    bit   mact[3] = '{0, 0, 0};
    int   img[3][8][8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: image stored as a frame, every stride-aligned KxK window maxed directly.
    task automatic model_accept(input int i, input int pix, input bit sof);
        int r, c, k, s, m, ow, oh;
        exp_t e;
        k = KP[i]; s = SP[i];
        if (sof) begin mr[i] = 0; mc[i] = 0; mact[i] = 1'b1; end
        if (!mact[i]) return;
        r = mr[i]; c = mc[i];
        img[i][r][c] = pix;
        if (r >= k - 1 && c >= k - 1 && (r - k + 1) % s == 0 && (c - k + 1) % s == 0) begin
            m = 0;
            for (int dr = 0; dr < k; dr++)
                for (int dc = 0; dc < k; dc++)
                    if (img[i][r-dr][c-dc] > m) m = img[i][r-dr][c-dc];
            ow = (WP[i] - k) / s + 1;
            oh = (HP[i] - k) / s + 1;
            e.inst = i;
            e.pix = 8'(m);
            e.eol = ((c - k + 1) / s == ow - 1);
            e.eof = e.eol && ((r - k + 1) / s == oh - 1);
            e.cyc = cyc;
            e.chk_lat = lat_en;
            sb.push_back(e);
        end
        if (c == WP[i] - 1) begin
            mc[i] = 0;
            if (r == HP[i] - 1) begin mact[i] = 1'b0; mr[i] = 0; end
            else mr[i] = r + 1;
        end else mc[i] = c + 1;
    endtask

    task automatic send(input int i, input int pix, input bit sof, input int gap);
        bit acc;
        int n;
        if (gap > 0) begin
            in_valid[i] = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        in_valid[i] = 1'b1;
        in_pixel[i] = 8'(pix);
        in_sof[i]   = sof;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready[i];
            @(posedge clk);
            #1;
            n++;
        end
        in_valid[i] = 1'b0;
        in_sof[i]   = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
        else model_accept(i, pix, sof);
    endtask

    task automatic send_frame(input int i, input int mode, input int npix, input int maxgap);
        int r, c, pix, sel;
        for (int p = 0; p < npix; p++) begin
            r = p / WP[i];
            c = p % WP[i];
            case (mode)
                0: pix = r * WP[i] + c;
                1: pix = (r == 4 && c == 4) ? 255 : 0;
                default: begin
                    sel = $urandom_range(0, 7);
                    pix = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(0, 255);
                end
            endcase
            send(i, pix, p == 0, (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_pending", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (fd_pend[i] || frame_done[i] === 1'b1) chk("frame_done", int'(frame_done[i]), int'(fd_pend[i]));
            fd_pend[i] = 1'b0;
            if (!rst && out_valid[i] === 1'b1 && out_ready[i] === 1'b1) begin
                if (sb.size() == 0) chk("unexpected_output", i, -1);
                else begin
                    e = sb.pop_front();
                    chk("out_inst", i, e.inst);
                    chk("out_pixel", int'(out_pixel[i]), int'(e.pix));
                    chk("out_eol", int'(out_eol[i]), int'(e.eol));
                    chk("out_eof", int'(out_eof[i]), int'(e.eof));
                    if (e.chk_lat) chk("out_latency", cyc, e.cyc);
                    fd_pend[i] = out_eof[i];
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy)
                for (int i = 0; i < 3; i++) out_ready[i] = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; in_sof[i] = 1'b0; in_pixel[i] = 8'd0; out_ready[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_out_valid", int'(out_valid[i]), 0);
            chk("reset_in_ready", int'(in_ready[i]), 1);
            chk("reset_busy", int'(busy[i]), 0);
            chk("reset_out_pixel", int'(out_pixel[i]), 0);
            chk("reset_eol_eof", int'({out_eol[i], out_eof[i]}), 0);
        end
        @(posedge clk); #1;

        // Directed frames with exact latency checks
        send_frame(0, 0, 16, 0); drain();
        send_frame(1, 0, 16, 0); drain();
        send_frame(2, 1, 49, 0); drain();

        // Back-pressure on the first result
        lat_en = 1'b0;
        out_ready[0] = 1'b0;
        fork
            send_frame(0, 0, 16, 0);
            begin
                n = 0;
                while (out_valid[0] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    chk("bp_valid", int'(out_valid[0]), 1);
                    chk("bp_pixel", int'(out_pixel[0]), 5);
                    chk("bp_in_ready", int'(in_ready[0]), 0);
                end
                @(posedge clk); #1;
                out_ready[0] = 1'b1;
            end
        join
        drain();
        lat_en = 1'b1;

        // Junk before sof is dropped; second sof mid-frame restarts
        for (int k = 0; k < 3; k++) send(0, 99, 1'b0, 0);
        send_frame(0, 0, 6, 0);
        send_frame(0, 0, 16, 0);
        drain();

        // Reset with a result pending
        out_ready[1] = 1'b0;
        send_frame(1, 0, 11, 0);
        chk("pre_rst_valid", int'(out_valid[1]), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_out_valid", int'(out_valid[1]), 0);
        chk("rst_busy", int'(busy[1]), 0);
        chk("rst_in_ready", int'(in_ready[1]), 1);
        sb.delete();
        for (int i = 0; i < 3; i++) begin mact[i] = 1'b0; fd_pend[i] = 1'b0; end
        out_ready[1] = 1'b1;
        send_frame(1, 0, 16, 0);
        drain();

        // Randomized pixels, input gaps and output stalls
        lat_en = 1'b0;
        rand_rdy = 1'b1;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 3; i++) send_frame(i, 2, WP[i] * HP[i], 2);
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        for (int i = 0; i < 3; i++) out_ready[i] = 1'b1;
        drain();
        for (int i = 0; i < 3; i++) chk("end_busy", int'(busy[i]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
